// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants, address table and state encoding for the RTC reader
package rtc_pkg;

  localparam int         N_TRANS   = 10;
  localparam logic [3:0] LAST_IDX  = 4'(N_TRANS - 1);
  localparam logic [7:0] CMD_LATCH = 8'hF0;

  localparam logic [7:0] ADDR_SREL  = 8'h21;
  localparam logic [7:0] ADDR_MREL  = 8'h22;
  localparam logic [7:0] ADDR_HREL  = 8'h23;
  localparam logic [7:0] ADDR_DIA   = 8'h24;
  localparam logic [7:0] ADDR_MES   = 8'h25;
  localparam logic [7:0] ADDR_ANIO  = 8'h26;
  localparam logic [7:0] ADDR_HCRON = 8'h41;
  localparam logic [7:0] ADDR_MCRON = 8'h42;
  localparam logic [7:0] ADDR_SCRON = 8'h43;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP1,
    ST_DATA,
    ST_GAP2,
    ST_DONE
  } state_t;

  // Index 0 is the shadow-latch command; 1..9 are the register reads in display order.
  function automatic logic [7:0] addr_of(input logic [3:0] idx);
    logic [7:0] a;
    a = CMD_LATCH;
    case (idx)
      4'd1:    a = ADDR_SREL;
      4'd2:    a = ADDR_MREL;
      4'd3:    a = ADDR_HREL;
      4'd4:    a = ADDR_DIA;
      4'd5:    a = ADDR_MES;
      4'd6:    a = ADDR_ANIO;
      4'd7:    a = ADDR_HCRON;
      4'd8:    a = ADDR_MCRON;
      4'd9:    a = ADDR_SCRON;
      default: a = CMD_LATCH;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_bus_fase.sv
// rtl/rtc_bus_fase.sv - per-phase strobe decode and T_PH phase counter for the RTC bus
module rtc_bus_fase
  import rtc_pkg::*;
#(
  parameter int T_PH = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  state_t     state_i,
  input  logic       wr_data_i,
  input  logic [7:0] addr_i,
  output logic       last_o,
  output logic       cs_n_o,
  output logic       rd_n_o,
  output logic       wr_n_o,
  output logic       a_d_o,
  output logic       ad_oe_o,
  output logic [7:0] ad_out_o
);

  localparam logic [7:0] CNT_LAST = 8'(T_PH - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       active;

  assign active = (state_i == ST_ADDR) || (state_i == ST_GAP1) ||
                  (state_i == ST_DATA) || (state_i == ST_GAP2);

  // All four bus phases share one length, so the counter simply wraps.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!active || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = active && (cnt_q == CNT_LAST);

  always_comb begin
    cs_n_o   = 1'b1;
    rd_n_o   = 1'b1;
    wr_n_o   = 1'b1;
    a_d_o    = 1'b1;
    ad_oe_o  = 1'b0;
    ad_out_o = 8'h00;
    case (state_i)
      ST_ADDR: begin
        cs_n_o   = 1'b0;
        a_d_o    = 1'b0;
        wr_n_o   = 1'b0;
        ad_oe_o  = 1'b1;
        ad_out_o = addr_i;
      end
      ST_DATA: begin
        cs_n_o = 1'b0;
        if (wr_data_i) begin
          wr_n_o  = 1'b0;
          ad_oe_o = 1'b1;
        end else begin
          rd_n_o = 1'b0;
        end
      end
      default: begin
        cs_n_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rtc_lectura.sv
// rtl/rtc_lectura.sv - sequences the latch command plus nine RTC register reads
// and publishes the whole clock/date/timer set in one cycle.
module rtc_lectura
  import rtc_pkg::*;
#(
  parameter int T_PH = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic       busy,
  output logic       done,
  output logic [7:0] SREL,
  output logic [7:0] MREL,
  output logic [7:0] HREL,
  output logic [7:0] DIA,
  output logic [7:0] MES,
  output logic [7:0] ANIO,
  output logic [7:0] SCRON,
  output logic [7:0] MCRON,
  output logic [7:0] HCRON
);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       last;
  logic       capture;
  logic       load;
  logic [7:0] shadow_q [1:9];
  logic [7:0] out_q    [1:9];

  rtc_bus_fase #(
    .T_PH(T_PH)
  ) u_bus (
    .clk      (clk),
    .reset    (reset),
    .state_i  (state_q),
    .wr_data_i(idx_q == 4'd0),
    .addr_i   (addr_of(idx_q)),
    .last_o   (last),
    .cs_n_o   (cs_n),
    .rd_n_o   (rd_n),
    .wr_n_o   (wr_n),
    .a_d_o    (a_d),
    .ad_oe_o  (ad_oe),
    .ad_out_o (ad_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ADDR;
          idx_d   = '0;
        end
      end
      ST_ADDR: if (last) state_d = ST_GAP1;
      ST_GAP1: if (last) state_d = ST_DATA;
      ST_DATA: if (last) state_d = ST_GAP2;
      ST_GAP2: begin
        if (last) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ADDR;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs load on the edge into DONE so the full set is already valid during the done pulse.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    done    = (state_q == ST_DONE);
    capture = (state_q == ST_DATA) && last && (idx_q != 4'd0);
    load    = (state_q == ST_GAP2) && last && (idx_q == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= 9; i++) begin
        shadow_q[i] <= '0;
        out_q[i]    <= '0;
      end
    end else begin
      if (capture) begin
        shadow_q[idx_q] <= ad_in;
      end
      if (load) begin
        for (int i = 1; i <= 9; i++) begin
          out_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign SREL  = out_q[1];
  assign MREL  = out_q[2];
  assign HREL  = out_q[3];
  assign DIA   = out_q[4];
  assign MES   = out_q[5];
  assign ANIO  = out_q[6];
  assign HCRON = out_q[7];
  assign MCRON = out_q[8];
  assign SCRON = out_q[9];

endmodule

// File: tb/tb_rtc_lectura.sv
// tb/tb_rtc_lectura.sv - scoreboard bench for rtc_lectura with a behavioural RTC and bus-timing model
module tb_rtc_lectura;

  localparam int T_PH   = 10;
  localparam int RD_LEN = 40 * T_PH;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d, busy, done;
  logic [7:0] SREL, MREL, HREL, DIA, MES, ANIO, SCRON, MCRON, HCRON;

  always #5 clk = ~clk;

  rtc_lectura #(.T_PH(T_PH)) dut (
    .clk(clk), .reset(reset), .start(start), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
    .busy(busy), .done(done),
    .SREL(SREL), .MREL(MREL), .HREL(HREL), .DIA(DIA), .MES(MES), .ANIO(ANIO),
    .SCRON(SCRON), .MCRON(MCRON), .HCRON(HCRON)
  );

  typedef struct {
    logic [71:0] vals;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  regs  [256];
  logic [7:0]  addrs [10];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          m_active = 0;
  int          t0 = 0;
  int          n_accept = 0;
  int          n_done = 0;
  logic [71:0] m_out = '0;
  logic [71:0] m_cur = '0;

  // Display order: SREL MREL HREL DIA MES ANIO HCRON MCRON SCRON
  function automatic logic [71:0] snap();
    return {regs[8'h21], regs[8'h22], regs[8'h23], regs[8'h24], regs[8'h25],
            regs[8'h26], regs[8'h41], regs[8'h42], regs[8'h43]};
  endfunction

  function automatic logic [71:0] dut_outs();
    return {SREL, MREL, HREL, DIA, MES, ANIO, HCRON, MCRON, SCRON};
  endfunction

  // Reference model: a read occupies cycles t0 .. t0+RD_LEN, the last being the done cycle.
  always @(posedge clk) begin : model
    bit   was_idle;
    exp_t e;
    was_idle = !m_active;
    if (reset) begin
      m_active = 0;
      m_out    = '0;
      sb.delete();
    end else begin
      if (m_active && (cyc - t0 + 1) == RD_LEN + 1) begin
        m_active = 0;
      end else if (was_idle && start) begin
        m_active   = 1;
        t0         = cyc + 1;
        n_accept++;
        m_cur      = snap();
        e.vals     = m_cur;
        e.done_cyc = t0 + RD_LEN;
        sb.push_back(e);
      end
      if (m_active && (cyc + 1 - t0 + 1) == RD_LEN + 1) m_out = m_cur;
    end
    cyc++;
  end

  logic       e_cs, e_rd, e_wr, e_ad, e_oe, e_busy, e_done;
  logic [7:0] e_out;
  logic [7:0] lat_addr = 8'h00;
  int         k, ph, tr;
  int         rd_cnt = 0;

  always @(negedge clk) begin : monitor
    exp_t got;
    {e_cs, e_rd, e_wr, e_ad, e_oe, e_busy, e_done} = 7'b1111000;
    e_out = 8'h00;
    if (m_active) begin
      e_busy = 1'b1;
      k = cyc - t0 + 1;
      if (k == RD_LEN + 1) begin
        e_done = 1'b1;
      end else begin
        tr = (k - 1) / (4 * T_PH);
        ph = ((k - 1) / T_PH) % 4;
        if (ph == 0) begin
          e_cs = 1'b0; e_ad = 1'b0; e_wr = 1'b0; e_oe = 1'b1; e_out = addrs[tr];
        end else if (ph == 2) begin
          e_cs = 1'b0;
          if (tr == 0) begin
            e_wr = 1'b0; e_oe = 1'b1;
          end else begin
            e_rd = 1'b0;
          end
        end
      end
    end
    n_vec++;
    if ({cs_n, rd_n, wr_n, a_d, ad_oe, busy, done, ad_out} !==
        {e_cs, e_rd, e_wr, e_ad, e_oe, e_busy, e_done, e_out}) begin
      n_err++;
      $display("FAIL bus cyc=%0d: got cs_n,rd_n,wr_n,a_d,oe,busy,done,ad_out=%b%b%b%b%b%b%b %h, required %b%b%b%b%b%b%b %h",
               cyc, cs_n, rd_n, wr_n, a_d, ad_oe, busy, done, ad_out,
               e_cs, e_rd, e_wr, e_ad, e_oe, e_busy, e_done, e_out);
    end
    n_vec++;
    if (dut_outs() !== m_out) begin
      n_err++;
      $display("FAIL outputs_hold cyc=%0d: got %h, required %h", cyc, dut_outs(), m_out);
    end
    n_vec++;
    if (ad_oe === 1'b1 && rd_n === 1'b0) begin
      n_err++;
      $display("FAIL bus_contention cyc=%0d: ad_oe=1 with rd_n=0, required never both active", cyc);
    end
    if (done === 1'b1) begin
      n_done++;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done cyc=%0d: got done=1, required no pending read", cyc);
      end else begin
        got = sb.pop_front();
        if (dut_outs() !== got.vals || cyc != got.done_cyc) begin
          n_err++;
          $display("FAIL done_values: got %h at cyc %0d, required %h at cyc %0d",
                   dut_outs(), cyc, got.vals, got.done_cyc);
        end
      end
    end
    // RTC side: garbage on every DATA cycle except the last one of the phase.
    if (cs_n === 1'b0 && a_d === 1'b0 && wr_n === 1'b0) lat_addr = ad_out;
    if (cs_n === 1'b0 && a_d === 1'b1 && rd_n === 1'b0) begin
      rd_cnt++;
      if (rd_cnt == T_PH) ad_in = regs[lat_addr];
      else                ad_in = regs[lat_addr] ^ 8'($urandom_range(1, 255));
    end else begin
      rd_cnt = 0;
      ad_in  = 8'($urandom);
    end
  end

  task automatic wait_idle();
    int i;
    i = 0;
    while (m_active && i < 1000) begin
      @(posedge clk); #1;
      i++;
    end
    n_vec++;
    if (m_active) begin
      n_err++;
      $display("FAIL wait_idle: still active after %0d cycles, required idle", i);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic randomize_regs();
    for (int a = 0; a < 256; a++) regs[a] = 8'($urandom);
  endtask

  initial begin
    int d0, a0, i;
    reset = 1'b1;
    start = 1'b0;
    ad_in = 8'h00;
    addrs = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    randomize_regs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    regs[8'h21] = 8'h45; regs[8'h22] = 8'h59; regs[8'h23] = 8'h23;
    regs[8'h24] = 8'h31; regs[8'h25] = 8'h12; regs[8'h26] = 8'h16;
    regs[8'h41] = 8'h01; regs[8'h42] = 8'h30; regs[8'h43] = 8'h15;
    d0 = n_done;
    pulse_start();
    repeat (49) @(posedge clk);
    #1 pulse_start();
    repeat (149) @(posedge clk);
    #1 pulse_start();
    wait_idle();
    n_vec++;
    if (dut_outs() !== 72'h45_59_23_31_12_16_01_30_15 || n_done != d0 + 1) begin
      n_err++;
      $display("FAIL fixed_read: got %h done_count=%0d, required 455923311216013015 done_count=%0d",
               dut_outs(), n_done - d0, 1);
    end

    randomize_regs();
    d0 = n_done;
    pulse_start();
    repeat (149) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n_vec++;
    if (cs_n !== 1'b1 || ad_oe !== 1'b0 || busy !== 1'b0 || dut_outs() !== 72'h0) begin
      n_err++;
      $display("FAIL mid_reset: got cs_n=%b ad_oe=%b busy=%b outs=%h, required 1 0 0 0",
               cs_n, ad_oe, busy, dut_outs());
    end
    repeat (300) @(posedge clk);
    #1;
    n_vec++;
    if (n_done != d0) begin
      n_err++;
      $display("FAIL reset_no_done: got %0d done pulses, required 0", n_done - d0);
    end

    randomize_regs();
    d0 = n_done;
    a0 = n_accept;
    start = 1'b1;
    i = 0;
    while (n_accept < a0 + 2 && i < 1200) begin
      @(posedge clk); #1;
      i++;
    end
    start = 1'b0;
    wait_idle();
    n_vec++;
    if (n_done != d0 + 2) begin
      n_err++;
      $display("FAIL held_start: got %0d done pulses, required 2", n_done - d0);
    end

    for (int r = 0; r < 4; r++) begin
      randomize_regs();
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1 pulse_start();
      for (int c = 0; c < 380; c++) begin
        start = ($urandom_range(0, 19) == 0);
        @(posedge clk); #1;
      end
      start = 1'b0;
      wait_idle();
    end

    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending reads, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
